uart_count_packetizer: RTL and testbench
========================================

Name: uart_count_packetizer

Overview:
Sits upstream of the UART transmit path and acts as the byte source for it. It accepts 16-bit timebin index / 32-bit PMT count pairs from the counting logic and buffers them in a small FIFO. Each pair is framed into a fixed byte packet and fed one byte at a time over the UART transmit handshake (transmit / tx_byte / tx_Done). The host PC parses the resulting byte stream.

Parameters:
FIFO_AW, 3, log2 of FIFO depth (8 entries); legal range 1..6
SYNC_BYTE, 8'hA5, first byte of every packet
TX_TIMEOUT, 24'd2_000_000, cycles to wait for tx_done per byte before aborting the packet (about 40 ms at 50 MHz)

Ports:
clk  in  1  master clock
rst_n  in  1  synchronous reset, active low
count_valid  in  1  a count/bin pair is presented this cycle
count_ready  out  1  FIFO not full; a push occurs on valid&&ready
bin_index  in  16  timebin index
count_data  in  32  PMT count for that bin
ovf_clear  in  1  clears the overflow sticky bit
transmit  out  1  one-cycle request to the UART to send tx_byte
tx_byte  out  8  byte to send
tx_busy  in  1  UART is_transmitting
tx_done  in  1  UART tx_Done, a one-cycle pulse after the stop bits
pkt_sent  out  1  one-cycle pulse when the final byte of a packet completes
overflow  out  1  sticky: a pair was offered while the FIFO was full
tx_timeout  out  1  sticky: a byte was aborted on timeout; cleared by ovf_clear
fifo_level  out  FIFO_AW+1  current occupancy

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO is emptied; FSM returns to IDLE.
  - transmit=0, tx_byte=0, pkt_sent=0, overflow=0, tx_timeout=0, fifo_level=0, count_ready=1.
- Packet format, 8 bytes in this order:
  - SYNC_BYTE
  - idx[15:8], idx[7:0]
  - cnt[31:24], cnt[23:16], cnt[15:8], cnt[7:0]
  - CSUM = (sum of bytes 2..7) mod 256; the sync byte is excluded.
- FIFO:
  - First-word-fall-through, 48-bit entries.
  - count_ready = !full.
  - When full, push and pop in the same cycle is not possible: ready is already low, so the offered word is dropped.
  - count_valid && !count_ready sets overflow for that cycle and onward; the word is dropped; the producer is never stalled.
  - Overflow and ovf_clear in the same cycle: set wins.
- FSM states:
  - IDLE: if FIFO non-empty, go to LOAD.
  - LOAD: pop the FIFO; latch the word into a 64-bit shift register with CSUM precomputed; set byte_cnt=0; go to ARM.
  - ARM: present the current byte on tx_byte. When tx_busy=0, assert transmit for exactly one cycle and go to WAIT. If tx_busy=1, hold in ARM.
  - WAIT: tx_byte is held stable.
    - On tx_done: if byte_cnt==7, pulse pkt_sent and go to IDLE. Otherwise increment byte_cnt, shift in the next byte, go to ARM.
    - If the timeout counter reaches TX_TIMEOUT first: set tx_timeout, discard the rest of the packet, go to IDLE.
- Timing:
  - Latency: a push into an empty FIFO at cycle N gives transmit high at N+2, provided tx_busy=0.
  - Back-to-back packets: from pkt_sent, the next transmit follows 2 cycles later (IDLE, LOAD, ARM).
  - The packetizer never asserts transmit twice without an intervening tx_done.
  - tx_done seen outside WAIT is ignored.
- Reset mid-packet: the partial packet is lost. After reset the FSM still waits for tx_busy=0 in ARM, so a UART still finishing a byte is never interrupted.
- The timeout counter restarts on every ARM→WAIT transition and saturates at TX_TIMEOUT.

Optional Feature:
PKT_SEQ_EN
- Defined:
  - A 9-byte packet with an 8-bit sequence byte inserted after SYNC_BYTE.
  - The sequence counter resets to 0 and increments (wrapping 255→0) on every pkt_sent. Aborted packets do not increment it.
  - CSUM also includes the sequence byte.
- Undefined: the 8-byte packet described above; no counter logic.

Decomposition:
- Package uart_pkt_pkg: SYNC_BYTE default, PKT_LEN (8, or 9 under PKT_SEQ_EN), the FSM state enum (IDLE, LOAD, ARM, WAIT), and the 48-bit FIFO entry struct {idx, cnt}.
- One sub-module: pkt_sync_fifo, a parameterised synchronous FWFT FIFO with full/empty/level outputs and active-low synchronous reset.

Test Plan:
- Single pair: idx=0x0012, cnt=0x000001F4, UART model returning tx_done 10 cycles after transmit → bytes A5 00 12 00 00 01 F4 07, then one pkt_sent pulse.
- Nine pairs pushed on consecutive cycles with the UART stalled → count_ready low after 8 pushes, 9th word dropped, overflow=1, fifo_level=8. Then ovf_clear → overflow=0 and 8 packets are sent in order.
- tx_busy held high for 50 cycles while in ARM → transmit stays 0 throughout. transmit pulses exactly once, on the cycle after tx_busy falls.
- tx_done never returned on byte 3, with TX_TIMEOUT set to 100 → tx_timeout=1 after 100 cycles, no pkt_sent. The next FIFO entry starts with A5.
- rst_n low during WAIT of byte 5 → all outputs reach their reset values on the next edge, fifo_level=0. With tx_busy high after reset, no transmit occurs until tx_busy falls.
- PKT_SEQ_EN build: three packets of idx=0, cnt=0 → sequence bytes 00, 01, 02; checksums 00, 01, 02.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkt_pkg
// Description : Shared types and constants for the UART count packetizer.
//               Packet length, FSM state encoding, FIFO entry layout and the
//               checksum helper all live here.
// Config      : PKT_SEQ_EN - adds a sequence byte after the sync byte
//               (9-byte packet instead of 8).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

`ifdef PKT_SEQ_EN
  localparam int PKT_LEN = 9;
`else
  localparam int PKT_LEN = 8;
`endif

  localparam int PKT_W  = PKT_LEN * 8;
  // Everything between the sync byte and the checksum byte
  localparam int BODY_W = PKT_W - 16;
  localparam logic [3:0] LAST_BYTE = 4'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ARM  = 2'd2,
    WAIT = 2'd3
  } pkt_state_e;

  typedef struct packed {
    logic [15:0] idx;
    logic [31:0] cnt;
  } fifo_entry_t;

  // Modulo-256 sum of the packet body; the sync byte is never included.
  function automatic logic [7:0] pkt_csum(input logic [BODY_W-1:0] body);
    logic [7:0] sum;
    sum = 8'd0;
    for (int i = 0; i < BODY_W / 8; i++) begin
      sum = sum + body[i*8 +: 8];
    end
    return sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pkt_sync_fifo
// Description : Synchronous first-word-fall-through FIFO. dout shows the head
//               entry whenever empty is low; pop consumes it.
// Ports       : clk, rst_n (sync, active low)
//               push/din/full  - write side, push ignored when full
//               pop/dout/empty - read side, pop ignored when empty
//               level          - current occupancy (0..2**AW)
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_sync_fifo #(
  parameter int AW = 3,
  parameter int DW = 48
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  output logic          full,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == DEPTH[AW:0]);
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/uart_count_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : uart_count_packetizer
// Description : Buffers timebin/count pairs and frames each one into a byte
//               packet {SYNC, [SEQ], idx[15:8], idx[7:0], cnt[31:24..7:0],
//               CSUM} fed byte-by-byte to a UART transmitter.
// Config      : PKT_SEQ_EN - inserts a wrapping 8-bit sequence byte after the
//               sync byte; it advances on every completed packet.
// Ports       : clk, rst_n (sync, active low)
//               count_valid/count_ready/bin_index/count_data - pair input
//               ovf_clear  - clears overflow and tx_timeout sticky bits
//               transmit/tx_byte/tx_busy/tx_done - UART transmit handshake
//               pkt_sent   - pulse when the last byte of a packet completes
//               overflow   - sticky, a pair was dropped on a full FIFO
//               tx_timeout - sticky, a packet was aborted waiting on tx_done
//               fifo_level - current FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module uart_count_packetizer
  import uart_pkt_pkg::*;
#(
  parameter int          FIFO_AW    = 3,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter logic [23:0] TX_TIMEOUT = 24'd2_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               count_valid,
  output logic               count_ready,
  input  logic [15:0]        bin_index,
  input  logic [31:0]        count_data,
  input  logic               ovf_clear,
  output logic               transmit,
  output logic [7:0]         tx_byte,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic               pkt_sent,
  output logic               overflow,
  output logic               tx_timeout,
  output logic [FIFO_AW:0]   fifo_level
);

  fifo_entry_t fifo_din, fifo_dout;
  logic        fifo_full, fifo_empty, fifo_pop;

  pkt_state_e       state_q, state_d;
  logic [PKT_W-1:0] shreg_q, shreg_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [3:0]       byte_cnt_q, byte_cnt_d;
  logic [23:0]      timer_q, timer_d, timer_inc;
  logic             transmit_q, transmit_d;
  logic             pkt_sent_q, pkt_sent_d;
  logic             overflow_q, overflow_d;
  logic             tx_timeout_q, tx_timeout_d;

  logic [BODY_W-1:0] body;
  logic [PKT_W-1:0]  next_pkt;

  assign fifo_din.idx = bin_index;
  assign fifo_din.cnt = count_data;

  pkt_sync_fifo #(
    .AW (FIFO_AW),
    .DW ($bits(fifo_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (count_valid),
    .din   (fifo_din),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef PKT_SEQ_EN
  logic [7:0] seq_q, seq_d;
  assign body = {seq_q, fifo_dout.idx, fifo_dout.cnt};
`else
  assign body = {fifo_dout.idx, fifo_dout.cnt};
`endif

  assign next_pkt  = {SYNC_BYTE, body, pkt_csum(body)};
  assign timer_inc = timer_q + 24'd1;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    tx_byte_d    = tx_byte_q;
    byte_cnt_d   = byte_cnt_q;
    timer_d      = timer_q;
    transmit_d   = 1'b0;
    pkt_sent_d   = 1'b0;
    overflow_d   = overflow_q;
    tx_timeout_d = tx_timeout_q;
    fifo_pop     = 1'b0;
`ifdef PKT_SEQ_EN
    seq_d        = seq_q;
`endif

    // Clears come first so any set in this cycle overrides them.
    if (ovf_clear) begin
      overflow_d   = 1'b0;
      tx_timeout_d = 1'b0;
    end
    if (count_valid && fifo_full) overflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        fifo_pop   = 1'b1;
        shreg_d    = next_pkt;
        tx_byte_d  = next_pkt[PKT_W-1 -: 8];
        byte_cnt_d = 4'd0;
        // Launch decision is made a cycle early so transmit is a flop and
        // coincides with the first ARM cycle when the UART is idle.
        transmit_d = !tx_busy;
        state_d    = ARM;
      end
      ARM: begin
        if (transmit_q) begin
          timer_d = 24'd0;
          state_d = WAIT;
        end else begin
          transmit_d = !tx_busy;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (byte_cnt_q == LAST_BYTE) begin
            pkt_sent_d = 1'b1;
            state_d    = IDLE;
`ifdef PKT_SEQ_EN
            seq_d      = seq_q + 8'd1;
`endif
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
            shreg_d    = shreg_q << 8;
            tx_byte_d  = shreg_q[PKT_W-9 -: 8];
            transmit_d = !tx_busy;
            state_d    = ARM;
          end
        end else begin
          // Counter stops at TX_TIMEOUT because the FSM leaves WAIT there.
          timer_d = timer_inc;
          if (timer_inc == TX_TIMEOUT) begin
            tx_timeout_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      tx_byte_q    <= 8'd0;
      byte_cnt_q   <= 4'd0;
      timer_q      <= 24'd0;
      transmit_q   <= 1'b0;
      pkt_sent_q   <= 1'b0;
      overflow_q   <= 1'b0;
      tx_timeout_q <= 1'b0;
`ifdef PKT_SEQ_EN
      seq_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      tx_byte_q    <= tx_byte_d;
      byte_cnt_q   <= byte_cnt_d;
      timer_q      <= timer_d;
      transmit_q   <= transmit_d;
      pkt_sent_q   <= pkt_sent_d;
      overflow_q   <= overflow_d;
      tx_timeout_q <= tx_timeout_d;
`ifdef PKT_SEQ_EN
      seq_q        <= seq_d;
`endif
    end
  end

  assign count_ready = !fifo_full;
  assign transmit    = transmit_q;
  assign tx_byte     = tx_byte_q;
  assign pkt_sent    = pkt_sent_q;
  assign overflow    = overflow_q;
  assign tx_timeout  = tx_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_count_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_count_packetizer
// Description : Directed bench for uart_count_packetizer with a simple UART
//               responder (tx_done 10 cycles after each transmit).
// Config      : PKT_SEQ_EN - enables the sequence-byte checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_count_packetizer;
  import uart_pkt_pkg::*;

  localparam int FIFO_AW = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              count_valid = 1'b0;
  logic              ovf_clear = 1'b0;
  logic [15:0]       bin_index = 16'd0;
  logic [31:0]       count_data = 32'd0;
  logic              count_ready, transmit, pkt_sent, overflow, tx_timeout;
  logic              tx_busy, tx_done;
  logic [7:0]        tx_byte;
  logic [FIFO_AW:0]  fifo_level;

  int vectors = 0;
  int miscompares = 0;

  // UART responder state
  logic       busy_force = 1'b0;
  logic       model_busy = 1'b0;
  logic       model_done = 1'b0;
  int         mcnt = 0;
  int         drop_idx = -1;
  int         cyc = 0;
  int         last_pkt_cyc = 0;
  logic       gap_pending = 1'b0;
  int         pkt_gap = -1;
  int         pkt_count = 0;
  int         tx_count = 0;
  int         violations = 0;
  logic [7:0] cap_q[$];

  assign tx_busy = busy_force | model_busy;
  assign tx_done = model_done;

  always #5 clk = ~clk;

  uart_count_packetizer #(
    .FIFO_AW    (FIFO_AW),
    .SYNC_BYTE  (8'hA5),
    .TX_TIMEOUT (24'd100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .count_valid (count_valid),
    .count_ready (count_ready),
    .bin_index   (bin_index),
    .count_data  (count_data),
    .ovf_clear   (ovf_clear),
    .transmit    (transmit),
    .tx_byte     (tx_byte),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .pkt_sent    (pkt_sent),
    .overflow    (overflow),
    .tx_timeout  (tx_timeout),
    .fifo_level  (fifo_level)
  );

  // UART responder: samples 1 ns after each rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    model_done = 1'b0;
    if (!rst_n) begin
      mcnt       = 0;
      model_busy = 1'b0;
    end else begin
      if (pkt_sent) begin
        pkt_count++;
        last_pkt_cyc = cyc;
        gap_pending  = 1'b1;
      end
      if (transmit) begin
        if (mcnt != 0) violations++;
        if (gap_pending) begin
          pkt_gap     = cyc - last_pkt_cyc;
          gap_pending = 1'b0;
        end
        cap_q.push_back(tx_byte);
        tx_count++;
        model_busy = 1'b1;
        mcnt       = 10;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          model_busy = 1'b0;
          if (drop_idx != cap_q.size() - 1) model_done = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] idx, input logic [31:0] cnt);
    bin_index   = idx;
    count_data  = cnt;
    count_valid = 1'b1;
    @(negedge clk);
    count_valid = 1'b0;
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int n = 0;
    while (pkt_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_pkts", 72'(pkt_count >= target), 72'd1);
  endtask

  task automatic wait_caps(input int target, input int budget);
    int n = 0;
    while (cap_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_bytes", 72'(cap_q.size() >= target), 72'd1);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_transmit"},    72'(transmit),    72'd0);
    check({pfx, "_tx_byte"},     72'(tx_byte),     72'd0);
    check({pfx, "_pkt_sent"},    72'(pkt_sent),    72'd0);
    check({pfx, "_overflow"},    72'(overflow),    72'd0);
    check({pfx, "_tx_timeout"},  72'(tx_timeout),  72'd0);
    check({pfx, "_fifo_level"},  72'(fifo_level),  72'd0);
    check({pfx, "_count_ready"}, 72'(count_ready), 72'd1);
  endtask

  // Expected packet, right-aligned, first byte most significant.
  function automatic logic [71:0] exp_pkt(input logic [15:0] idx, input logic [31:0] cnt,
                                          input logic [7:0] seq);
    logic [7:0]  b [9];
    logic [7:0]  s;
    logic [71:0] p;
    int          n;
    n = 0;
    b[n] = 8'hA5;       n = n + 1;
`ifdef PKT_SEQ_EN
    b[n] = seq;         n = n + 1;
`else
    if (seq === 8'hxx) n = n + 0;
`endif
    b[n] = idx[15:8];   n = n + 1;
    b[n] = idx[7:0];    n = n + 1;
    b[n] = cnt[31:24];  n = n + 1;
    b[n] = cnt[23:16];  n = n + 1;
    b[n] = cnt[15:8];   n = n + 1;
    b[n] = cnt[7:0];    n = n + 1;
    s = 8'd0;
    for (int i = 1; i < n; i++) s = s + b[i];
    b[n] = s;           n = n + 1;
    p = '0;
    for (int i = 0; i < n; i++) p = {p[63:0], b[i]};
    return p;
  endfunction

  function automatic logic [71:0] got_pkt(input int start);
    logic [71:0] p;
    p = '0;
    for (int i = 0; i < PKT_LEN; i++) begin
      if (start + i < cap_q.size()) p = {p[63:0], cap_q[start + i]};
      else                          p = {p[63:0], 8'hEE};
    end
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          tx0;
    logic [7:0]  exp_seq;
    logic [15:0] e_idx;
    logic [31:0] e_cnt;

    exp_seq = 8'd0;

    // ---- reset values ----
    rst_n = 1'b0;
    tick(3);
    check_reset("rst");
    rst_n = 1'b1;
    tick(2);

`ifdef PKT_SEQ_EN
    // ---- sequence byte: three all-zero pairs ----
    cap_q.delete();
    base = pkt_count;
    push(16'h0000, 32'h0);
    push(16'h0000, 32'h0);
    push(16'h0000, 32'h0);
    wait_pkts(base + 3, 600);
    check("seq0",  72'(cap_q[1]),  72'h00);
    check("seq1",  72'(cap_q[10]), 72'h01);
    check("seq2",  72'(cap_q[19]), 72'h02);
    check("csum0", 72'(cap_q[8]),  72'h00);
    check("csum1", 72'(cap_q[17]), 72'h01);
    check("csum2", 72'(cap_q[26]), 72'h02);
    exp_seq = 8'd3;
    tick(4);
`endif

    // ---- single pair, latency and packet content ----
    cap_q.delete();
    base = pkt_count;
    push(16'h0012, 32'h0000_01F4);
    check("lat_n0", 72'(transmit), 72'd0);
    tick(1);
    check("lat_n1", 72'(transmit), 72'd0);
    tick(1);
    check("lat_n2", 72'(transmit), 72'd1);
    check("lat_byte", 72'(tx_byte), 72'hA5);
    wait_pkts(base + 1, 400);
`ifdef PKT_SEQ_EN
    check("single_pkt", got_pkt(0), exp_pkt(16'h0012, 32'h0000_01F4, exp_seq));
`else
    check("single_pkt", got_pkt(0), 72'h00_A5_00_12_00_00_01_F4_07);
`endif
    exp_seq = exp_seq + 8'd1;
    tick(5);
    check("single_pkt_count", 72'(pkt_count - base), 72'd1);

    // ---- UART stalled: hold in ARM, fill FIFO, overflow ----
    cap_q.delete();
    base = pkt_count;
    tx0  = tx_count;
    busy_force = 1'b1;
    push(16'h0100, 32'h0000_0100);
    tick(4);
    check("arm_level0", 72'(fifo_level), 72'd0);
    for (int i = 1; i <= 9; i++) begin
      bin_index   = 16'h0100 + 16'(i);
      count_data  = 32'(32'h1111_1111 * i);
      count_valid = 1'b1;
      @(negedge clk);
      if (i == 8) begin
        check("full_ready", 72'(count_ready), 72'd0);
        check("full_level", 72'(fifo_level),  72'd8);
      end
    end
    count_valid = 1'b0;
    check("ovf_set",   72'(overflow),   72'd1);
    check("ovf_level", 72'(fifo_level), 72'd8);
    count_valid = 1'b1;
    ovf_clear   = 1'b1;
    tick(1);
    count_valid = 1'b0;
    check("ovf_set_wins", 72'(overflow), 72'd1);
    tick(1);
    ovf_clear = 1'b0;
    check("ovf_cleared", 72'(overflow), 72'd0);
    tick(36);
    check("arm_hold_no_tx", 72'(tx_count - tx0), 72'd0);
    busy_force = 1'b0;
    tick(1);
    check("arm_release_tx",   72'(transmit), 72'd1);
    check("arm_release_byte", 72'(tx_byte),  72'hA5);
    wait_pkts(base + 9, 3000);
    check("b2b_gap", 72'(pkt_gap), 72'd2);
    for (int k = 0; k < 9; k++) begin
      if (k == 0) begin
        e_idx = 16'h0100;
        e_cnt = 32'h0000_0100;
      end else begin
        e_idx = 16'h0100 + 16'(k);
        e_cnt = 32'(32'h1111_1111 * k);
      end
      check("burst_pkt", got_pkt(k * PKT_LEN), exp_pkt(e_idx, e_cnt, exp_seq));
      exp_seq = exp_seq + 8'd1;
    end

    // ---- tx_done withheld on byte 3: abort, next packet intact ----
    cap_q.delete();
    base     = pkt_count;
    drop_idx = 3;
    push(16'hBEEF, 32'hCAFE_F00D);
    push(16'h0042, 32'h0000_0007);
    wait_caps(4, 200);
    tick(90);
    check("tmo_early", 72'(tx_timeout), 72'd0);
    tick(20);
    check("tmo_set",     72'(tx_timeout), 72'd1);
    check("tmo_no_sent", 72'(pkt_count - base), 72'd0);
    drop_idx = -1;
    wait_pkts(base + 1, 400);
    check("tmo_next_sync", 72'(cap_q[4]), 72'hA5);
    check("tmo_next_pkt",  got_pkt(4), exp_pkt(16'h0042, 32'h0000_0007, exp_seq));
    exp_seq = exp_seq + 8'd1;
    ovf_clear = 1'b1;
    tick(1);
    ovf_clear = 1'b0;
    check("tmo_cleared", 72'(tx_timeout), 72'd0);

    // ---- reset during WAIT of byte 5 ----
    cap_q.delete();
    push(16'h1234, 32'h5678_9ABC);
    push(16'h0001, 32'h0000_0002);
    wait_caps(6, 300);
    tick(3);
    check("pre_rst_level", 72'(fifo_level), 72'd1);
    rst_n = 1'b0;
    tick(1);
    check_reset("midrst");
    rst_n      = 1'b1;
    busy_force = 1'b1;
    exp_seq    = 8'd0;
    cap_q.delete();
    tx0  = tx_count;
    base = pkt_count;
    push(16'h00AA, 32'h0000_00BB);
    tick(20);
    check("rst_busy_no_tx", 72'(tx_count - tx0), 72'd0);
    busy_force = 1'b0;
    tick(1);
    check("rst_release_tx", 72'(transmit), 72'd1);
    wait_pkts(base + 1, 400);
    check("rst_next_pkt", got_pkt(0), exp_pkt(16'h00AA, 32'h0000_00BB, exp_seq));

    check("no_double_transmit", 72'(violations), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
